// File: rtl/pwm_output_stage.sv
// -----------------------------------------------------------------------------
// PwmOutputStage (module pwm_output_stage)
//
// Drives the 16 user output pins from the configuration registers written by
// the SPI register block. A prescaled 8-bit counter generates one shared PWM
// waveform. The duty cycle is held in a shadow register that reloads only when
// the counter wraps, so a period is never cut short or stretched.
//
// Each pin is selected by two enable bits:
//   en_out=0            -> pin low
//   en_out=1, en_pwm=0  -> pin static high
//   en_out=1, en_pwm=1  -> pin follows the PWM waveform
//
// Parameters:
//   PRESCALE         clk cycles per PWM counter step (1..65535)
//
// Ports:
//   clk              system clock, rising edge
//   rst              asynchronous active-high reset
//   en_reg_out_7_0   output enables, pins 7..0
//   en_reg_out_15_8  output enables, pins 15..8
//   en_reg_pwm_7_0   PWM-mode select, pins 7..0
//   en_reg_pwm_15_8  PWM-mode select, pins 15..8
//   pwm_duty_cycle   requested duty (0x00 = 0%, 0xFF = 100%)
//   out              registered pin drive
//   period_start     one-cycle pulse on the first cycle of each PWM period,
//                    aligned with the first pin value derived from count 0
// -----------------------------------------------------------------------------
module pwm_output_stage #(
    parameter int unsigned PRESCALE = 3000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  en_reg_out_7_0,
    input  logic [7:0]  en_reg_out_15_8,
    input  logic [7:0]  en_reg_pwm_7_0,
    input  logic [7:0]  en_reg_pwm_15_8,
    input  logic [7:0]  pwm_duty_cycle,
    output logic [15:0] out,
    output logic        period_start
);

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    logic [15:0] r_preCnt;
    logic [7:0]  r_pwmCnt;
    logic [7:0]  r_dutyQ;
    logic        r_wrapSeen;

    logic        w_tick;
    logic        w_wrap;
    logic        w_pwmRaw;
    logic [15:0] w_enOut;
    logic [15:0] w_enPwm;
    logic [15:0] w_outNext;

    assign w_tick  = (r_preCnt == PRE_LAST);
    assign w_wrap  = w_tick && (r_pwmCnt == 8'hFF);
    assign w_enOut = {en_reg_out_15_8, en_reg_out_7_0};
    assign w_enPwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

    // 0xFF is special-cased so the top duty value means a solid high level;
    // a plain compare would leave one low step per period.
    assign w_pwmRaw  = (r_dutyQ == 8'hFF) || (r_pwmCnt < r_dutyQ);
    assign w_outNext = w_enOut & (~w_enPwm | {16{w_pwmRaw}});

    // Prescaler: counts 0..PRESCALE-1 and advances the PWM counter on tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_preCnt <= '0;
        end else if (w_tick) begin
            r_preCnt <= '0;
        end else begin
            r_preCnt <= r_preCnt + 16'd1;
        end
    end

    // PWM counter wraps naturally from 255 to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pwmCnt <= '0;
        end else if (w_tick) begin
            r_pwmCnt <= r_pwmCnt + 8'd1;
        end
    end

    // Duty shadow reloads on the wrap edge only, so the new value governs
    // the whole of the next period and the current one is left intact.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dutyQ <= '0;
        end else if (w_wrap) begin
            r_dutyQ <= pwm_duty_cycle;
        end
    end

    // period_start is delayed twice from the wrap: once to reach the first
    // count-0 cycle, and once more to line up with the registered pins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrapSeen   <= 1'b0;
            period_start <= 1'b0;
        end else begin
            r_wrapSeen   <= w_wrap;
            period_start <= r_wrapSeen;
        end
    end

    // All pins share one register stage so PWM pins stay phase-aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out <= '0;
        end else begin
            out <= w_outNext;
        end
    end

endmodule

// File: tb/tb_pwm_output_stage.sv
// -----------------------------------------------------------------------------
// Testbench for pwm_output_stage with PRESCALE=2 (512-cycle PWM period).
// A reference model running on the clock pushes the expected
// {period_start, out} for each edge into a queue; the scenario tasks pop one
// entry per cycle and compare, alongside hand-derived high-time and
// period-length checks.
// -----------------------------------------------------------------------------
module tb_pwm_output_stage;

    localparam int P = 2;
    localparam int L = 256 * P;
    localparam int BOUND = L + 64;

    logic        clk;
    logic        rst;
    logic [15:0] enOut;
    logic [15:0] enPwm;
    logic [7:0]  duty;
    logic [15:0] out;
    logic        period_start;

    int checks;
    int errors;

    logic [16:0] sbq[$];
    logic [15:0] expOut;
    logic        expPs;

    int          mCycle;
    logic [7:0]  mDuty;
    int          mPcnt;
    logic        mRaw;
    logic [15:0] mOut;
    logic        mPs;

    pwm_output_stage #(
        .PRESCALE(P)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .en_reg_out_7_0 (enOut[7:0]),
        .en_reg_out_15_8(enOut[15:8]),
        .en_reg_pwm_7_0 (enPwm[7:0]),
        .en_reg_pwm_15_8(enPwm[15:8]),
        .pwm_duty_cycle (duty),
        .out            (out),
        .period_start   (period_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: derives counter position from the cycle count since
    // reset release and predicts the pin values the next edge produces.
    always @(posedge clk) begin
        if (rst) begin
            mCycle = 0;
            mDuty  = 8'h00;
            sbq.push_back(17'h0);
        end else begin
            mPcnt = (mCycle / P) % 256;
            mRaw  = (mDuty == 8'hFF) || (mPcnt < int'(mDuty));
            mOut  = enOut & (~enPwm | {16{mRaw}});
            mPs   = ((mCycle % L) == 0) && (mCycle > 0);
            if ((mCycle % L) == (L - 1)) mDuty = duty;
            mCycle++;
            sbq.push_back({mPs, mOut});
        end
    end

    // Advance one clock and fetch the prediction for the new output state.
    task automatic nextCycle();
        @(posedge clk);
        #1;
        if (sbq.size() > 0) begin
            {expPs, expOut} = sbq.pop_front();
        end else begin
            expPs  = 1'bx;
            expOut = 'x;
        end
    endtask

    // Step until period_start is seen or the bound expires.
    task automatic syncToPeriod(output int n);
        n = 0;
        while (period_start !== 1'b1 && n < BOUND) begin
            nextCycle();
            n++;
        end
    endtask

    // Run from one period_start to the next, counting cycles where all
    // masked pins are high and cycles that disagree with the model.
    task automatic runPeriod(input logic [15:0] mask, input int writeAt,
                             input logic [7:0] writeVal,
                             output int len, output int high, output int sbBad);
        len = 0; high = 0; sbBad = 0;
        do begin
            if ({period_start, out} !== {expPs, expOut}) sbBad++;
            if ((out & mask) === mask) high++;
            if (len == writeAt) duty = writeVal;
            nextCycle();
            len++;
        end while (period_start !== 1'b1 && len < BOUND);
    endtask

    task automatic test_reset();
        enOut = 16'($urandom);
        enPwm = 16'($urandom);
        duty  = 8'($urandom);
        rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            checks++;
            if ({period_start, out} !== 17'h0 || {expPs, expOut} !== 17'h0) begin
                errors++;
                $display("[TB] FAIL reset_hold: ps/out=%b/%h expected 0/0000", period_start, out);
            end
        end
        rst   = 1'b0;
        enOut = 16'h0000;
        enPwm = 16'h0000;
        duty  = 8'h00;
        #1;
        checks++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_release: ps/out=%b/%h expected 0/0000", period_start, out);
        end
    endtask

    task automatic test_static_enables();
        enOut = 16'h8001;
        nextCycle();
        checks++;
        if (out !== 16'h8001 || {period_start, out} !== {expPs, expOut}) begin
            errors++;
            $display("[TB] FAIL static_on: out=%h expected 8001", out);
        end
        enOut = 16'h0000;
        nextCycle();
        checks++;
        if (out !== 16'h0000 || {period_start, out} !== {expPs, expOut}) begin
            errors++;
            $display("[TB] FAIL static_off: out=%h expected 0000", out);
        end
    endtask

    task automatic test_duty_50();
        int n, len, high, sbBad, firstHalf;
        enOut = 16'hFFFF;
        enPwm = 16'hFFFF;
        duty  = 8'h80;
        n = 0; sbBad = 0;
        while (period_start !== 1'b1 && n < BOUND) begin
            if ({period_start, out} !== {expPs, expOut}) sbBad++;
            if (out !== 16'h0000) sbBad++;
            nextCycle();
            n++;
        end
        checks++;
        if (period_start !== 1'b1 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL first_period: ps=%b diffs=%0d expected ps=1 diffs=0", period_start, sbBad);
        end
        len = 0; high = 0; firstHalf = 0; sbBad = 0;
        do begin
            if ({period_start, out} !== {expPs, expOut}) sbBad++;
            if (out === 16'hFFFF) begin
                high++;
                if (len < 256) firstHalf++;
            end
            nextCycle();
            len++;
        end while (period_start !== 1'b1 && len < BOUND);
        checks++;
        if (len != L) begin
            errors++;
            $display("[TB] FAIL duty50_spacing: got %0d cycles expected %0d", len, L);
        end
        checks++;
        if (high != 256 || firstHalf != 256) begin
            errors++;
            $display("[TB] FAIL duty50_high: high=%0d first_half=%0d expected 256/256", high, firstHalf);
        end
        checks++;
        if (sbBad != 0) begin
            errors++;
            $display("[TB] FAIL duty50_scoreboard: diffs=%0d expected 0", sbBad);
        end
    endtask

    task automatic test_extremes();
        int len, high, sbBad;
        duty = 8'h00;
        runPeriod(16'hFFFF, -1, 8'h00, len, high, sbBad);
        checks++;
        if (high != 256 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL held_50: high=%0d diffs=%0d expected 256/0", high, sbBad);
        end
        duty = 8'hFF;
        runPeriod(16'hFFFF, -1, 8'h00, len, high, sbBad);
        checks++;
        if (high != 0 || len != L || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL duty00: high=%0d len=%0d diffs=%0d expected 0/%0d/0", high, len, sbBad, L);
        end
        runPeriod(16'hFFFF, -1, 8'h00, len, high, sbBad);
        checks++;
        if (high != L || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL dutyFF_a: high=%0d diffs=%0d expected %0d/0", high, sbBad, L);
        end
        runPeriod(16'hFFFF, 300, 8'h40, len, high, sbBad);
        checks++;
        if (high != L || len != L || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL dutyFF_b: high=%0d len=%0d diffs=%0d expected %0d/%0d/0", high, len, sbBad, L, L);
        end
    endtask

    task automatic test_mid_period_change();
        int len, high, sbBad;
        runPeriod(16'hFFFF, 19, 8'hC0, len, high, sbBad);
        checks++;
        if (high != 128 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL mid_current: high=%0d diffs=%0d expected 128/0", high, sbBad);
        end
        runPeriod(16'hFFFF, 5, 8'h40, len, high, sbBad);
        checks++;
        if (high != 384 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL mid_next: high=%0d diffs=%0d expected 384/0", high, sbBad);
        end
    endtask

    task automatic test_mixed_and_reset();
        int len, high, sbBad, n, lowBad;
        enOut = 16'h00FF;
        enPwm = 16'h000F;
        runPeriod(16'h000F, -1, 8'h00, len, high, sbBad);
        checks++;
        if (high != 128 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL mixed_pwm_high: high=%0d diffs=%0d expected 128/0", high, sbBad);
        end
        checks++;
        if (out !== 16'h00FF) begin
            errors++;
            $display("[TB] FAIL mixed_start: out=%h expected 00FF", out);
        end
        sbBad = 0;
        for (int i = 1; i <= 200; i++) begin
            nextCycle();
            if ({period_start, out} !== {expPs, expOut}) sbBad++;
            if (i == 30) begin
                checks++;
                if (out !== 16'h00FF) begin
                    errors++;
                    $display("[TB] FAIL mixed_high_phase: out=%h expected 00FF", out);
                end
            end
        end
        checks++;
        if (out !== 16'h00F0 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL mixed_low_phase: out=%h diffs=%0d expected 00F0/0", out, sbBad);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || period_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: ps/out=%b/%h expected 0/0000", period_start, out);
        end
        nextCycle();
        nextCycle();
        checks++;
        if (out !== 16'h0000 || {period_start, out} !== {expPs, expOut}) begin
            errors++;
            $display("[TB] FAIL reset_held: out=%h expected 0000", out);
        end
        rst = 1'b0;
        nextCycle();
        checks++;
        if (out !== 16'h00F0 || {period_start, out} !== {expPs, expOut}) begin
            errors++;
            $display("[TB] FAIL restart_first: out=%h expected 00F0", out);
        end
        n = 1; lowBad = 0; sbBad = 0;
        while (period_start !== 1'b1 && n < BOUND) begin
            if (out !== 16'h00F0) lowBad++;
            if ({period_start, out} !== {expPs, expOut}) sbBad++;
            nextCycle();
            n++;
        end
        checks++;
        if (n != L + 1 || lowBad != 0 || sbBad != 0) begin
            errors++;
            $display("[TB] FAIL restart_period: edges=%0d wrong_pins=%0d diffs=%0d expected %0d/0/0",
                     n, lowBad, sbBad, L + 1);
        end
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        enOut  = 16'h0000;
        enPwm  = 16'h0000;
        duty   = 8'h00;
        test_reset();
        test_static_enables();
        test_duty_50();
        test_extremes();
        test_mid_period_change();
        test_mixed_and_reset();
        syncToPeriod(n);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pwm_output_stage.md
# pwm_output_stage

Drives the 16 user output pins from the five configuration registers written by the SPI register block (output enables, PWM enables, duty cycle). It contains a prescaled 8-bit PWM counter and a duty-cycle shadow register that updates only at period boundaries, so the PWM waveform never glitches. Each pin is forced low, driven static high, or driven by the shared PWM waveform, selected by its enable bits.

## Interface
- PRESCALE, 3000: clk cycles per PWM counter step. Legal range 1..65535.
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en_reg_out_7_0  input  8  output enables, pins 7..0.
- en_reg_out_15_8  input  8  output enables, pins 15..8.
- en_reg_pwm_7_0  input  8  PWM-mode select, pins 7..0.
- en_reg_pwm_15_8  input  8  PWM-mode select, pins 15..8.
- pwm_duty_cycle  input  8  requested duty cycle; 0x00 means 0%, 0xFF means 100%.
- out  output  16  registered pin drive.
- period_start  output  1  one-cycle pulse marking the first cycle of each PWM period.

## Operation
- All inputs are synchronous to clk; the upstream block registers them on the same clock, so this block adds no synchronizers.
- Prescaler `pre_cnt` is 16-bit and counts 0..PRESCALE-1, then wraps to 0.
  - `tick` = (pre_cnt == PRESCALE-1).
  - With PRESCALE=1, `tick` is asserted every cycle.
- PWM counter `pwm_cnt` is 8-bit and increments on `tick`, wrapping from 255 to 0. A period is 256·PRESCALE clk cycles.
- Duty shadow `duty_q` (8-bit) loads `pwm_duty_cycle` only in the cycle where `tick` is high and pwm_cnt==255, i.e. the cycle in which the counter wraps.
- PWM waveform `pwm_raw`:
  - 1 when duty_q==0xFF.
  - Otherwise 1 when pwm_cnt < duty_q.
  - Resulting high time is duty_q·PRESCALE cycles per period, and full period when duty_q is 0xFF.
- Per pin i, with en_out = {en_reg_out_15_8, en_reg_out_7_0} and en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0}: next out[i] = en_out[i] & (~en_pwm[i] | pwm_raw).
  - en_out=0: pin is low.
  - en_out=1, en_pwm=0: pin is high.
  - en_out=1, en_pwm=1: pin follows the PWM waveform.
- period_start is registered and is 1 in the same cycle out first reflects pwm_cnt==0.

## Timing
- Reset values: out=0, period_start=0, pre_cnt=0, pwm_cnt=0, duty_q=0. They take effect immediately on rst assertion, independent of clk.
- After reset deasserts, the first wrap (and so the first duty_q load) occurs 256·PRESCALE cycles later. Until then all PWM-mode pins are low.
- Enable changes appear on out exactly 1 cycle later.
- Duty changes appear at the next period boundary only. A mid-period write never alters the current period.
  - A write in the same cycle as the wrap is captured (same-edge load).
  - Multiple writes within one period: the last value before the wrap wins.
- Pin output latency relative to pwm_cnt is 1 cycle, and it is identical for all pins, so PWM pins are phase-aligned.
- period_start pulses exactly once per 256·PRESCALE cycles. It is never two cycles wide, including with PRESCALE=1.
- Reset asserted mid-period: outputs drop at once. After release, counting restarts from 0 with duty_q=0.

## Test plan
All scenarios use PRESCALE=2.
- **Reset:** assert rst with random inputs → out=0x0000, period_start=0 while rst is high and on the first cycle after release.
- **Static enables:** en_out=0x8001, en_pwm=0 → out=0x8001 one cycle later; then en_out=0 → out=0x0000 one cycle later.
- **50% duty:** en_out=en_pwm=0xFFFF, duty=0x80 before the first wrap → after the first period_start, every pin is high for 256 cycles and low for 256 cycles; period_start spacing is 512 cycles.
- **Extremes:**
  - duty=0x00 → PWM pins are constantly low for a full period.
  - duty=0xFF → PWM pins are constantly high, with no low cycle across a boundary.
- **Mid-period change:** duty=0x40 loaded; write 0xC0 at pwm_cnt=10 → current period high time is 128 cycles; next period high time is 384 cycles.
- **Mixed modes and reset:**
  - en_out=0x00FF, en_pwm=0x000F, duty=0x40 → pins 3..0 pulse, pins 7..4 are static high, pins 15..8 are low.
  - Assert rst mid-period → out=0 asynchronously, before the next clk edge.
